// File: rtl/dig_data_bus_resp_pkg.sv
// Shared constants and types for the data-bus responder.
// The address map and the access classification are kept here so that
// the top level and any other user of the map agree on them.
package dig_data_bus_resp_pkg;

  localparam int unsigned ADDR_CFG_BASE = 32'h00;
  localparam int unsigned ADDR_STATUS   = 32'h10;
  localparam int unsigned ADDR_IRQ_FLAG = 32'h11;
  localparam int unsigned ADDR_IRQ_MASK = 32'h12;
  localparam int unsigned ADDR_ID       = 32'h13;

  localparam logic [7:0] RESP_ID = 8'hA5;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2
  } acc_kind_e;

  // Classify the bus strobe; wr_en is ignored when no access is in flight.
  function automatic acc_kind_e decode_acc(input logic acc_en, input logic wr_en);
    if (!acc_en)    return ACC_IDLE;
    else if (wr_en) return ACC_WR;
    else            return ACC_RD;
  endfunction

endpackage

// File: rtl/dig_data_bus_resp_irq.sv
// Interrupt flag/mask pair for the data-bus responder.
// Flags are set by hardware event pulses and cleared by write-1-to-clear;
// a set and clear of the same bit in one cycle leaves the bit set.
// irq_o is registered and tracks |(flag & mask) as held in the registers.
module dig_data_bus_resp_irq
  import dig_data_bus_resp_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DWIDTH-1:0] evt_i,
  input  logic [DWIDTH-1:0] clr_i,
  input  logic              mask_we_i,
  input  logic [DWIDTH-1:0] mask_wdata_i,
  output logic [DWIDTH-1:0] flag_o,
  output logic [DWIDTH-1:0] mask_o,
  output logic              irq_o
);

  logic [DWIDTH-1:0] flag_q, flag_d;
  logic [DWIDTH-1:0] mask_q, mask_d;
  logic              irq_q, irq_d;

  // Next-state: OR-ing the events in last makes set win over clear.
  // irq is computed from the next-state values so the registered irq_o
  // always equals |(flag_q & mask_q).
  always_comb begin
    flag_d = (flag_q & ~clr_i) | evt_i;
    mask_d = mask_we_i ? mask_wdata_i : mask_q;
    irq_d  = |(flag_d & mask_d);
  end

  // Flag, mask and interrupt registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flag_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign flag_o = flag_q;
  assign mask_o = mask_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/dig_data_bus_responder.sv
// Responder end of the digital data bus: config registers for the filter
// datapath, a live status register, an ID register and an interrupt
// flag/mask pair. Read data is registered (one-cycle latency).
// Optional feature macro: DIG_BUS_RESP_ERR_EN adds err_o, a one-cycle
// pulse after any unmapped access or any write to STATUS/ID.
module dig_data_bus_responder
  import dig_data_bus_resp_pkg::*;
#(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int NUM_CFG = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      acc_en_i,
  input  logic                      wr_en_i,
  input  logic [AWIDTH-1:0]         addr_i,
  input  logic [DWIDTH-1:0]         wdata_i,
  output logic [DWIDTH-1:0]         rdata_o,
  output logic [NUM_CFG*DWIDTH-1:0] cfg_o,
  input  logic [DWIDTH-1:0]         status_i,
  input  logic [DWIDTH-1:0]         irq_evt_i,
`ifdef DIG_BUS_RESP_ERR_EN
  output logic                      err_o,
`endif
  output logic                      irq_o
);

  acc_kind_e acc;
  logic      hit_cfg, hit_status, hit_flag, hit_mask, hit_id, mapped;

  logic [NUM_CFG-1:0][DWIDTH-1:0] cfg_q, cfg_d;
  logic [DWIDTH-1:0]              rdata_q, rdata_d;
  logic [DWIDTH-1:0]              rd_val;
  logic [DWIDTH-1:0]              irq_clr;
  logic [DWIDTH-1:0]              irq_flag, irq_mask;

  // Full-width address decode, so upper address bits never alias.
  always_comb begin
    acc        = decode_acc(acc_en_i, wr_en_i);
    hit_cfg    = (addr_i < AWIDTH'(ADDR_CFG_BASE + NUM_CFG));
    hit_status = (addr_i == AWIDTH'(ADDR_STATUS));
    hit_flag   = (addr_i == AWIDTH'(ADDR_IRQ_FLAG));
    hit_mask   = (addr_i == AWIDTH'(ADDR_IRQ_MASK));
    hit_id     = (addr_i == AWIDTH'(ADDR_ID));
    mapped     = hit_cfg | hit_status | hit_flag | hit_mask | hit_id;
  end

  // Read mux: current register contents; unmapped addresses read as 0.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (addr_i == AWIDTH'(ADDR_CFG_BASE + k)) rd_val = cfg_q[k];
    if (hit_status) rd_val = status_i;
    if (hit_flag)   rd_val = irq_flag;
    if (hit_mask)   rd_val = irq_mask;
    if (hit_id)     rd_val = DWIDTH'(RESP_ID);
  end

  // Next-state for config array and read-data register.
  always_comb begin
    cfg_d   = cfg_q;
    rdata_d = rdata_q;
    if (acc == ACC_WR) begin
      for (int k = 0; k < NUM_CFG; k++)
        if (addr_i == AWIDTH'(ADDR_CFG_BASE + k)) cfg_d[k] = wdata_i;
    end
    if (acc == ACC_RD) rdata_d = rd_val;
  end

  // Config and read-data registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q   <= '0;
      rdata_q <= '0;
    end else begin
      cfg_q   <= cfg_d;
      rdata_q <= rdata_d;
    end
  end

  assign irq_clr = (acc == ACC_WR && hit_flag) ? wdata_i : '0;

  dig_data_bus_resp_irq #(.DWIDTH(DWIDTH)) u_irq (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .evt_i        (irq_evt_i),
    .clr_i        (irq_clr),
    .mask_we_i    (acc == ACC_WR && hit_mask),
    .mask_wdata_i (wdata_i),
    .flag_o       (irq_flag),
    .mask_o       (irq_mask),
    .irq_o        (irq_o)
  );

  assign rdata_o = rdata_q;
  assign cfg_o   = cfg_q;

`ifdef DIG_BUS_RESP_ERR_EN
  logic err_q, err_d;

  // Illegal access: anything unmapped, or a write to a read-only register.
  always_comb begin
    err_d = (acc != ACC_IDLE) &&
            (!mapped || (acc == ACC_WR && (hit_status || hit_id)));
  end

  // Error pulse register.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_mapped;
  assign unused_mapped = mapped;
`endif

endmodule
